// File: rtl/shift_reg_param_pkg.sv
// Shared types and helpers for the shift_reg_param slice: FSM states,
// mode encodings and the bit-counter width function.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SIPO_RX = 2'd1,
    PISO_TX = 2'd2
  } state_t;

  localparam logic MODE_SIPO = 1'b0;
  localparam logic MODE_PISO = 1'b1;

  // Wide enough to hold WIDTH itself (the parity cycle counts to WIDTH).
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_reg_param_bit_counter.sv
// Modulo counter with enable, synchronous clear and terminal-count flag.
// Wraps to zero when enabled on the terminal value MAX.
module bit_counter #(
  parameter int CW  = 3,
  parameter int MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  localparam logic [CW-1:0] TC_VAL = CW'(MAX);

  assign tc = (cnt == TC_VAL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (en)    cnt <= tc ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/shift_reg_param.sv
// Parametrised SIPO/PISO shift register with framing counter and strobes.
// Define SHIFT_PARITY_EN to add the parity output and the PISO parity bit.
module shift_reg_param
  import shift_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             in,
  input  logic             in_en,
  input  logic [WIDTH-1:0] pin,
  input  logic             load,
  output logic [WIDTH-1:0] q,
  output logic             pvalid,
  output logic             sout,
  output logic             busy,
  output logic             done
`ifdef SHIFT_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CW = cnt_width(WIDTH);
`ifdef SHIFT_PARITY_EN
  localparam int TX_BITS = WIDTH + 1;
`else
  localparam int TX_BITS = WIDTH;
`endif
  localparam logic [CW-1:0] RX_LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sr, sr_rx, sr_tx;
  logic [CW-1:0]    cnt;
  logic             tx_last, rx_last;
  logic             rx_shift, rx_done, tx_start, tx_step, tx_end;
  logic             cnt_en, cnt_clr, tx_first, tx_next;
`ifdef SHIFT_PARITY_EN
  logic             tx_par;
`endif

  // One counter serves both directions; SIPO completion clears it early.
  bit_counter #(.CW(CW), .MAX(TX_BITS - 1)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .cnt (cnt),
    .tc  (tx_last)
  );

  assign rx_last = (cnt == RX_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (mode == MODE_SIPO && in_en)     state_nx = SIPO_RX;
        else if (mode == MODE_PISO && load) state_nx = PISO_TX;
      end
      SIPO_RX: if (in_en && rx_last) state_nx = IDLE;
      PISO_TX: if (tx_last)          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rx_shift = in_en && ((state == IDLE && mode == MODE_SIPO) || state == SIPO_RX);
    rx_done  = (state == SIPO_RX) && in_en && rx_last;
    tx_start = (state == IDLE) && (mode == MODE_PISO) && load;
    tx_step  = (state == PISO_TX);
    tx_end   = tx_step && tx_last;
    cnt_en   = rx_shift || tx_step;
    cnt_clr  = rx_done || tx_end;
    sr_rx    = MSB_FIRST ? {sr[WIDTH-2:0], in} : {in, sr[WIDTH-1:1]};
    sr_tx    = MSB_FIRST ? (sr << 1) : (sr >> 1);
    tx_first = MSB_FIRST ? pin[WIDTH-1] : pin[0];
    tx_next  = MSB_FIRST ? sr[WIDTH-2] : sr[1];
`ifdef SHIFT_PARITY_EN
    if (cnt == RX_LAST) tx_next = tx_par;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr     <= '0;
      q      <= '0;
      pvalid <= 1'b0;
      sout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      pvalid <= rx_done;
      done   <= tx_end;
      if (rx_shift) sr <= sr_rx;
      if (rx_done)  q  <= sr_rx;
      if (tx_start) begin
        sr   <= pin;
        sout <= tx_first;
        busy <= 1'b1;
      end else if (tx_end) begin
        sout <= 1'b0;
        busy <= 1'b0;
      end else if (tx_step) begin
        sr   <= sr_tx;
        sout <= tx_next;
      end
    end
  end

`ifdef SHIFT_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
      tx_par <= 1'b0;
    end else begin
      if (rx_done)  parity <= ^sr_rx;
      if (tx_start) tx_par <= ^pin;
    end
  end
`endif

endmodule

// File: tb/tb_shift_reg_param.sv
// Bench for shift_reg_param: one MSB-first and one LSB-first instance share
// stimulus; expectations come from a bit-list model of framing and serial order.
module tb_shift_reg_param;

  localparam int W = 4;
`ifdef SHIFT_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic clk = 1'b0, rst = 1'b0, mode = 1'b0, in = 1'b0, in_en = 1'b0, load = 1'b0;
  logic [W-1:0] pin = '0;
  logic [W-1:0] q_m, q_l;
  logic pv_m, pv_l, so_m, so_l, bz_m, bz_l, dn_m, dn_l;
`ifdef SHIFT_PARITY_EN
  logic par_m, par_l;
`endif

  int total = 0, bad = 0;

  // reference model state
  int           rx_cnt = 0;
  logic [W-1:0] rx_bits = '0;
  logic [W-1:0] eq_m = '0, eq_l = '0;
  bit           stim_en[$];
  bit           stim_bit[$];

  always #5 clk = ~clk;

  shift_reg_param #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .mode(mode), .in(in), .in_en(in_en), .pin(pin), .load(load),
    .q(q_m), .pvalid(pv_m), .sout(so_m), .busy(bz_m), .done(dn_m)
`ifdef SHIFT_PARITY_EN
    , .parity(par_m)
`endif
  );

  shift_reg_param #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .mode(mode), .in(in), .in_en(in_en), .pin(pin), .load(load),
    .q(q_l), .pvalid(pv_l), .sout(so_l), .busy(bz_l), .done(dn_l)
`ifdef SHIFT_PARITY_EN
    , .parity(par_l)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    rx_cnt = 0;
    eq_m   = '0;
    eq_l   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #8;
    total++;
    if ({q_m, pv_m, so_m, bz_m, dn_m, q_l, pv_l, so_l, bz_l, dn_l} !== '0) begin
      bad++;
      $display("FAIL reset: got qm=%b qm_flags=%b%b%b%b ql=%b ql_flags=%b%b%b%b want all 0",
               q_m, pv_m, so_m, bz_m, dn_m, q_l, pv_l, so_l, bz_l, dn_l);
    end
    #2 rst = 1'b1;
    model_clear();
  endtask

  // Plays stim_en/stim_bit one cycle per entry and checks every cycle.
  task automatic test_sipo(input string name);
    logic epv;
    load = 1'b0;
    for (int i = 0; i < stim_en.size(); i++) begin
      // mode only matters while no frame is in progress
      mode  = (rx_cnt != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_en = stim_en[i];
      in    = stim_bit[i];
      epv   = 1'b0;
      if (in_en) begin
        rx_bits[rx_cnt] = in;
        rx_cnt++;
        if (rx_cnt == W) begin
          for (int b = 0; b < W; b++) begin
            eq_m[W-1-b] = rx_bits[b];
            eq_l[b]     = rx_bits[b];
          end
          rx_cnt = 0;
          epv    = 1'b1;
        end
      end
      tick();
      total++;
      if ({q_m, pv_m, bz_m, so_m, dn_m} !== {eq_m, epv, 3'b000}) begin
        bad++;
        $display("FAIL %s msb cyc=%0d: got q=%b pv=%b busy=%b sout=%b done=%b want q=%b pv=%b idle",
                 name, i, q_m, pv_m, bz_m, so_m, dn_m, eq_m, epv);
      end
      total++;
      if ({q_l, pv_l, bz_l, so_l, dn_l} !== {eq_l, epv, 3'b000}) begin
        bad++;
        $display("FAIL %s lsb cyc=%0d: got q=%b pv=%b busy=%b sout=%b done=%b want q=%b pv=%b idle",
                 name, i, q_l, pv_l, bz_l, so_l, dn_l, eq_l, epv);
      end
`ifdef SHIFT_PARITY_EN
      total++;
      if ({par_m, par_l} !== {^eq_m, ^eq_l}) begin
        bad++;
        $display("FAIL %s parity cyc=%0d: got %b%b want %b%b", name, i, par_m, par_l, ^eq_m, ^eq_l);
      end
`endif
    end
    in_en = 1'b0;
    mode  = 1'b0;
  endtask

  task automatic test_sipo_basic();
    stim_en  = '{1, 1, 1, 1, 0};
    stim_bit = '{1, 0, 1, 0, 0};
    test_sipo("sipo_basic");
    total++;
    if ({q_m, q_l} !== {4'b1010, 4'b0101}) begin
      bad++;
      $display("FAIL sipo_basic frame: got %b/%b want 1010/0101", q_m, q_l);
    end
  endtask

  task automatic test_sipo_gaps();
    stim_en  = '{1, 1, 0, 0, 0, 1, 1, 0};
    stim_bit = '{1, 1, 0, 1, 0, 0, 1, 1};
    test_sipo("sipo_gaps");
    total++;
    if ({q_m, q_l} !== {4'b1101, 4'b1011}) begin
      bad++;
      $display("FAIL sipo_gaps frame: got %b/%b want 1101/1011", q_m, q_l);
    end
  endtask

  task automatic test_back_to_back();
    stim_en  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    stim_bit = '{1, 0, 0, 1, 1, 1, 1, 0, 0};
    test_sipo("sipo_b2b");
    total++;
    if ({q_m, q_l} !== {4'b1110, 4'b0111}) begin
      bad++;
      $display("FAIL sipo_b2b frame: got %b/%b want 1110/0111", q_m, q_l);
    end
  endtask

  task automatic test_sipo_random();
    int ones;
    bit e;
    ones = 0;
    stim_en.delete();
    stim_bit.delete();
    for (int i = 0; i < 150; i++) begin
      e = ($urandom_range(0, 3) != 0);
      stim_en.push_back(e);
      stim_bit.push_back(1'($urandom_range(0, 1)));
      if (e) ones++;
    end
    // finish on a frame boundary so later tests start from IDLE
    while (ones % W != 0) begin
      stim_en.push_back(1'b1);
      stim_bit.push_back(1'($urandom_range(0, 1)));
      ones++;
    end
    test_sipo("sipo_random");
  endtask

  task automatic test_reset_mid();
    stim_en  = '{1, 1};
    stim_bit = '{1, 1};
    test_sipo("pre_abort");
    #3 rst = 1'b0;
    #1;
    total++;
    if ({q_m, pv_m, so_m, bz_m, dn_m, q_l, pv_l, so_l, bz_l, dn_l} !== '0) begin
      bad++;
      $display("FAIL reset_mid_sipo: got qm=%b ql=%b flags=%b%b%b%b/%b%b%b%b want all 0",
               q_m, q_l, pv_m, so_m, bz_m, dn_m, pv_l, so_l, bz_l, dn_l);
    end
    #2 rst = 1'b1;
    model_clear();
    mode = 1'b1; pin = 4'b1111; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({so_m, bz_m, dn_m, so_l, bz_l, dn_l} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mid_piso: got sout/busy/done=%b%b%b %b%b%b want 0",
               so_m, bz_m, dn_m, so_l, bz_l, dn_l);
    end
    #2 rst = 1'b1;
    tick();
    total++;
    if ({so_m, bz_m, dn_m, so_l, bz_l, dn_l} !== 6'b0) begin
      bad++;
      $display("FAIL reset_mid_nodone: got sout/busy/done=%b%b%b %b%b%b want 0",
               so_m, bz_m, dn_m, so_l, bz_l, dn_l);
    end
    mode = 1'b0;
    stim_en  = '{1, 1, 1, 1};
    stim_bit = '{0, 0, 1, 1};
    test_sipo("post_abort");
    total++;
    if ({q_m, q_l} !== {4'b0011, 4'b1100}) begin
      bad++;
      $display("FAIL post_abort frame: got %b/%b want 0011/1100", q_m, q_l);
    end
  endtask

  // Sends frames; first uses pin 'first', the rest random. Spurious loads
  // with junk pin are thrown in while busy.
  task automatic test_piso(input string name, input logic [W-1:0] first, input int frames,
                           input bit b2b);
    logic [W-1:0] p;
    logic em, el;
    mode = 1'b1; in_en = 1'b0;
    p = first; pin = p; load = 1'b1;
    tick();
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < NB; k++) begin
        if (k < W) begin
          em = p[W-1-k];
          el = p[k];
        end else begin
          em = ^p;
          el = ^p;
        end
        total++;
        if ({q_m, q_l, pv_m, pv_l, so_m, so_l, bz_m, bz_l, dn_m, dn_l} !==
            {eq_m, eq_l, 2'b00, em, el, 4'b1100}) begin
          bad++;
          $display("FAIL %s f=%0d bit=%0d: got sout=%b%b busy=%b%b done=%b%b pv=%b%b q=%b/%b want sout=%b%b busy=11 done=00",
                   name, f, k, so_m, so_l, bz_m, bz_l, dn_m, dn_l, pv_m, pv_l, q_m, q_l, em, el);
        end
        load = ($urandom_range(0, 2) == 0);
        pin  = W'($urandom);
        tick();
      end
      total++;
      if ({so_m, so_l, bz_m, bz_l, dn_m, dn_l} !== 6'b000011) begin
        bad++;
        $display("FAIL %s f=%0d done cycle: got sout=%b%b busy=%b%b done=%b%b want 000011",
                 name, f, so_m, so_l, bz_m, bz_l, dn_m, dn_l);
      end
      if (f + 1 < frames && b2b) begin
        p = W'($urandom); pin = p; load = 1'b1;
        tick();
      end else begin
        load = 1'b0;
        tick();
        total++;
        if ({so_m, so_l, bz_m, bz_l, dn_m, dn_l} !== 6'b0) begin
          bad++;
          $display("FAIL %s f=%0d idle: got sout=%b%b busy=%b%b done=%b%b want 0",
                   name, f, so_m, so_l, bz_m, bz_l, dn_m, dn_l);
        end
        if (f + 1 < frames) begin
          p = W'($urandom); pin = p; load = 1'b1;
          tick();
        end
      end
    end
    load = 1'b0;
    mode = 1'b0;
  endtask

  task automatic test_parity();
    stim_en  = '{1, 1, 1, 1, 0};
    stim_bit = '{1, 0, 1, 1, 0};
    test_sipo("parity_sipo");
    total++;
    if (q_m !== 4'b1011) begin
      bad++;
      $display("FAIL parity_sipo frame: got %b want 1011", q_m);
    end
    test_piso("parity_piso", 4'b1011, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_sipo_basic();
    test_sipo_gaps();
    test_back_to_back();
    test_reset_mid();
    test_sipo_random();
    test_piso("piso_0110", 4'b0110, 1, 1'b0);
    test_piso("piso_b2b", 4'b1001, 6, 1'b1);
    test_piso("piso_gapped", 4'b1110, 3, 1'b0);
    test_sipo_random();
    test_parity();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
